// File: rtl/keytx_pkg.sv
// Shared definitions for the keypad sequence transmitter: FSM state encoding,
// the released-bus value, the key-index type and the index-to-line decode.
package keytx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_QUIET   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_RELEASED = 4'hF;

  typedef logic [1:0] key_idx_t;

  // Active-low line pattern for one pressed key; exactly one bit is zero.
  function automatic logic [3:0] key_decode(input key_idx_t k);
    return ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/keytx_timer.sv
// Phase timer: loadable down-counter that stops at zero and flags it.
module keytx_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/key_sequence_tx.sv
// Keypad sequence transmitter: presses a latched sequence of keys on the
// 4-line active-low keypad bus, each held HOLD cycles then released GAP
// cycles, followed by a QUIET window so the receiver returns to idle.
// Optional feature: define KEYTX_ABORT_EN to add an `abort` input that cuts
// the sequence short into the QUIET window.
module key_sequence_tx
  import keytx_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int HOLD   = 3,
  parameter int GAP    = 2,
  parameter int QUIET  = 8,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef KEYTX_ABORT_EN
  input  logic                abort,
`endif
  input  logic [2*N_KEYS-1:0] seq,
  output logic [3:0]          x,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_KEYS - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] QUIET_LD   = CNT_W'(QUIET - 1);

  if ((HOLD > (2**CNT_W) - 1) || (GAP > (2**CNT_W) - 1) || (QUIET > (2**CNT_W) - 1)) begin : g_cnt_w_check
    $error("key_sequence_tx: CNT_W too small for HOLD/GAP/QUIET");
  end

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [2*N_KEYS-1:0] sreg;
  logic [2*N_KEYS-1:0] sreg_nxt;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_zero;
  logic                abort_req;

`ifdef KEYTX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Next key always sits in the low two bits after one shift.
  assign sreg_nxt = sreg >> 2;

  keytx_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer reload decisions, made on the same edge as the matching state change.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_PRESS: begin
        if (abort_req) begin
          tmr_load = 1'b1;
          tmr_val  = QUIET_LD;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_RELEASE: begin
        if (abort_req) begin
          tmr_load = 1'b1;
          tmr_val  = QUIET_LD;
        end else if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = (idx == LAST_IDX) ? QUIET_LD : HOLD_LD;
        end
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  // Sequencer FSM with registered bus, busy and done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      x     <= KEY_RELEASED;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sreg  <= seq;
            idx   <= '0;
            x     <= key_decode(key_idx_t'(seq[1:0]));
            busy  <= 1'b1;
            state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (abort_req) begin
            x     <= KEY_RELEASED;
            state <= ST_QUIET;
          end else if (tmr_zero) begin
            x     <= KEY_RELEASED;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (abort_req) begin
            state <= ST_QUIET;
          end else if (tmr_zero) begin
            if (idx == LAST_IDX) begin
              state <= ST_QUIET;
            end else begin
              idx   <= idx + 1'b1;
              sreg  <= sreg_nxt;
              x     <= key_decode(key_idx_t'(sreg_nxt[1:0]));
              state <= ST_PRESS;
            end
          end
        end
        ST_QUIET: begin
          if (tmr_zero) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          x     <= KEY_RELEASED;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
